// File: rtl/ascii_result_streamer.sv
// ascii_result_streamer: strips leading pad characters from a right-justified ASCII
// result and streams the remaining bytes over a valid/ready byte interface.
module ascii_result_streamer #(
  parameter int          NCHARS      = 16,
  parameter logic [7:0]  PAD_CHAR    = 8'h20,
  parameter bit          APPEND_TERM = 1'b1,
  parameter logic [7:0]  TERM_CHAR   = 8'h0A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [8*NCHARS-1:0] result,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  localparam int            IW   = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHARS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    TERM = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IW-1:0]       idx_r, idx_s;
  logic [8*NCHARS-1:0] buf_r, buf_s;
  logic [7:0]          cur_s;
  logic [7:0]          out_data_r, out_data_s;
  logic                out_valid_r, out_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  // Character i counts from the left, so index 0 lives in the MSB byte.
  function automatic logic [7:0] char_at(input logic [8*NCHARS-1:0] b, input logic [IW-1:0] i);
    char_at = b[8*(NCHARS-1-int'(i)) +: 8];
  endfunction

  function automatic logic is_pad(input logic [7:0] c);
    is_pad = (c == PAD_CHAR) || (c == 8'h00);
  endfunction

  // State, index, buffer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      buf_r       <= {(8*NCHARS){1'b0}};
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      buf_r       <= buf_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  // Next state, character index and buffer capture
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    buf_s   = buf_r;
    cur_s   = char_at(buf_r, idx_r);
    case (state_r)
      IDLE: begin
        if (load) begin
          state_s = SCAN;
          idx_s   = {IW{1'b0}};
          buf_s   = result;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (!is_pad(cur_s)) begin
          state_s = SEND;
        end else if (idx_r == LAST) begin
          state_s = APPEND_TERM ? TERM : IDLE;
        end else begin
          idx_s = idx_r + IW'(1);
        end
      end
      SEND: begin
        if (out_valid_r && out_ready) begin
          if (idx_r == LAST) begin
            state_s = APPEND_TERM ? TERM : IDLE;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          state_s = SEND;
        end
      end
      TERM: begin
        if (out_valid_r && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = TERM;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output values are computed from the upcoming state so they register with it
  always_comb begin
    out_valid_s = 1'b0;
    out_data_s  = 8'h00;
    busy_s      = (state_s != IDLE);
    done_s      = 1'b0;
    case (state_s)
      SEND: begin
        out_valid_s = 1'b1;
        out_data_s  = char_at(buf_s, idx_s);
      end
      TERM: begin
        out_valid_s = 1'b1;
        out_data_s  = TERM_CHAR;
      end
      IDLE: done_s = (state_r != IDLE);
      default: out_valid_s = 1'b0;
    endcase
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_ascii_result_streamer.sv
// Self-checking bench for ascii_result_streamer: table vectors, hand-written corner
// sequences and random strings checked against a queue-based reference model.
module tb_ascii_result_streamer;

  logic         clk;
  logic         rst;
  logic         ld;
  logic         ld0;
  logic [127:0] result;
  logic         out_ready;
  logic [7:0]   od, od0;
  logic         ov, ov0, bz, bz0, dn, dn0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         exp_lat;

  localparam logic [127:0] S1010  = {{12{8'h20}}, "1010"};
  localparam logic [127:0] SFF    = {{14{8'h20}}, "FF"};
  localparam logic [127:0] SSPACE = {16{8'h20}};
  localparam logic [127:0] SZERO  = {16{8'h00}};
  localparam logic [127:0] SFULL  = "0000000111110100";

  ascii_result_streamer dut (
    .clk(clk), .rst(rst), .load(ld), .result(result), .out_ready(out_ready),
    .out_data(od), .out_valid(ov), .busy(bz), .done(dn)
  );

  ascii_result_streamer #(.APPEND_TERM(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(ld0), .result(result), .out_ready(out_ready),
    .out_data(od0), .out_valid(ov0), .busy(bz0), .done(dn0)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_ld(input bit t0, input bit v);
    ld  = !t0 && v;
    ld0 = t0 && v;
  endtask

  // Reference: strip leading space/NUL, keep the rest verbatim, optionally add LF.
  function automatic void build_expected(input logic [127:0] s, input bit term);
    int i0;
    logic [7:0] c;
    exp_q = {};
    i0 = -1;
    for (int i = 0; i < 16; i++) begin
      c = s[8*(15-i) +: 8];
      if (i0 < 0 && c != 8'h20 && c != 8'h00) i0 = i;
    end
    if (i0 >= 0)
      for (int i = i0; i < 16; i++) exp_q.push_back(s[8*(15-i) +: 8]);
    if (term) exp_q.push_back(8'h0A);
    exp_lat = (i0 >= 0) ? i0 + 1 : (term ? 16 : -1);
  endfunction

  // Entered at the negedge right after the load edge; runs until done.
  task automatic collect(input logic [127:0] s, input bit t0, input int mode, input bit spur,
                         input bit chain, input logic [127:0] nxt,
                         output int first, output int n);
    logic [7:0] got[$];
    logic [7:0] held, d;
    logic       v, b, fin_done, stall, rdy;
    int         edges, done_edge;
    bit         fin;
    logic [5:0] pat;
    pat = 6'b101001;
    build_expected(s, !t0);
    got = {};
    first = -1; done_edge = -1; fin = 1'b0; stall = 1'b0; edges = 0; held = 8'h00;
    while (!fin && edges < 300) begin
      v        = t0 ? ov0 : ov;
      d        = t0 ? od0 : od;
      b        = t0 ? bz0 : bz;
      fin_done = t0 ? dn0 : dn;
      if (edges == 0) chk(b == 1'b1 && fin_done == 1'b0, "busy_after_load", int'(b), 1);
      if (stall) chk(v == 1'b1 && d == held, "stall_hold", int'(d), int'(held));
      if (v && first < 0) first = edges;
      if (fin_done) begin
        fin = 1'b1;
        done_edge = edges;
        chk(!v && !b && d == 8'h00, "done_idle", int'({v, b, d}), 0);
        result = chain ? nxt : result;
        set_ld(t0, chain);
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = pat[edges % 6];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        out_ready = rdy;
        if (v && rdy) got.push_back(d);
        stall = v && !rdy;
        held  = d;
        if (spur && v) result = {$urandom, $urandom, $urandom, $urandom};
        set_ld(t0, spur && v);
      end
      @(negedge clk);
      edges++;
    end
    chk(fin, "done_timeout", edges, 300);
    chk(first == exp_lat, "first_valid_edge", first, exp_lat);
    chk(got.size() == exp_q.size(), "byte_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(got[i] == exp_q[i], $sformatf("byte%0d", i), int'(got[i]), int'(exp_q[i]));
    if (mode == 0 && fin)
      chk(done_edge == (exp_q.size() == 0 ? 16 : exp_lat + exp_q.size()), "done_edge",
          done_edge, (exp_q.size() == 0 ? 16 : exp_lat + exp_q.size()));
    n = got.size();
    if (!chain) begin
      set_ld(t0, 1'b0);
      chk((t0 ? dn0 : dn) == 1'b0 && (t0 ? bz0 : bz) == 1'b0, "done_one_cycle",
          int'(t0 ? dn0 : dn), 0);
    end
  endtask

  task automatic run(input logic [127:0] s, input bit t0, input int mode, input bit spur,
                     input bit chain, input logic [127:0] nxt, output int first, output int n);
    @(negedge clk);
    result = s;
    set_ld(t0, 1'b1);
    @(negedge clk);
    set_ld(t0, 1'b0);
    result = {$urandom, $urandom, $urandom, $urandom};
    collect(s, t0, mode, spur, chain, nxt, first, n);
  endtask

  typedef struct {
    logic [127:0] s;
    bit           t0;
    int           mode;
    int           exp_lat;
    int           exp_n;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int first, n, k, r, cnt;
    bit seen;
    logic [7:0] c;
    logic [127:0] rs;

    vecs[0] = '{S1010,  1'b0, 0, 13, 5};
    vecs[1] = '{S1010,  1'b0, 1, 13, 5};
    vecs[2] = '{SSPACE, 1'b0, 0, 16, 1};
    vecs[3] = '{SZERO,  1'b0, 0, 16, 1};
    vecs[4] = '{SSPACE, 1'b1, 0, -1, 0};
    vecs[5] = '{SZERO,  1'b1, 0, -1, 0};
    vecs[6] = '{SFULL,  1'b0, 1,  1, 17};
    vecs[7] = '{SFF,    1'b0, 0, 15, 3};
    vecs[8] = '{S1010,  1'b1, 1, 13, 4};

    clk = 1'b0; rst = 1'b1; ld = 1'b0; ld0 = 1'b0; result = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk(!ov && !bz && !dn && od == 8'h00, "reset_state", int'({ov, bz, dn, od}), 0);
    chk(!ov0 && !bz0 && !dn0 && od0 == 8'h00, "reset_state0", int'({ov0, bz0, dn0, od0}), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run(vecs[i].s, vecs[i].t0, vecs[i].mode, 1'b0, 1'b0, '0, first, n);
      chk(first == vecs[i].exp_lat, $sformatf("vec%0d_latency", i), first, vecs[i].exp_lat);
      chk(n == vecs[i].exp_n, $sformatf("vec%0d_count", i), n, vecs[i].exp_n);
    end

    // Load pulses during SEND are ignored; a load in the done cycle starts the next string.
    run(SFF, 1'b0, 0, 1'b1, 1'b1, S1010, first, n);
    chk(n == 3, "ff_spur_count", n, 3);
    collect(S1010, 1'b0, 0, 1'b0, 1'b0, '0, first, n);
    chk(first == 13 && n == 5, "chained_1010", n, 5);

    // Reset after the second byte of "1010" aborts without done.
    @(negedge clk);
    result = S1010; ld = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    cnt = 0;
    while (!ov && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk(ov == 1'b1, "rst_seq_valid", int'(ov), 1);
    repeat (2) @(negedge clk);
    chk(ov && od == 8'h31, "rst_seq_third_byte", int'(od), 8'h31);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(!ov && !bz && !dn && od == 8'h00, "rst_abort", int'({ov, bz, dn, od}), 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dn || ov || bz) seen = 1'b1;
    end
    chk(!seen, "rst_no_done", int'(seen), 0);
    run(SFULL, 1'b0, 0, 1'b0, 1'b0, '0, first, n);

    // Random strings with random leading pad runs and random ready.
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++) begin
        if (i < k) begin
          c = ($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00;
        end else begin
          r = $urandom_range(0, 17);
          c = (r < 10) ? 8'(8'h30 + r) : (r < 16) ? 8'(8'h41 + r - 10) : (r == 16) ? 8'h20 : 8'h00;
        end
        rs[8*(15-i) +: 8] = c;
      end
      run(rs, it[0], 2, it[2], 1'b0, '0, first, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
